mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DATA_W, default 32, width of data words.
REQ-002 Parameter: ADDR_W, default 32, width of memory addresses.
REQ-003 Parameter: RD_LAT, default 1, RAM read latency in clk cycles; legal range 1..3.
REQ-004 Port: clk  in  1  single clock; every register in the block SHALL be clocked on its rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: cpu_req  in  1  CPU access request; held high until cpu_gnt.
REQ-007 Port: cpu_we  in  1  1 = write, 0 = read; held stable while cpu_req is high.
REQ-008 Port: cpu_addr  in  ADDR_W  CPU address (MAR); held stable while cpu_req is high.
REQ-009 Port: cpu_wdata  in  DATA_W  CPU write data (MDR); held stable while cpu_req is high.
REQ-010 Port: cpu_gnt  out  1  one-cycle grant pulse; marks the cycle in which the CPU access is issued.
REQ-011 Port: cpu_rvalid  out  1  one-cycle pulse; cpu_rdata is valid in that cycle.
REQ-012 Port: cpu_rdata  out  DATA_W  CPU read data.
REQ-013 Port: dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata; same directions, widths and rules as the cpu_* ports.
REQ-014 Port: ram_addr  out  ADDR_W  address to the RAM.
REQ-015 Port: ram_data  out  DATA_W  write data to the RAM.
REQ-016 Port: ram_wren  out  1  RAM write enable.
REQ-017 Port: ram_q  in  DATA_W  RAM read data, valid RD_LAT cycles after the issue cycle.

Function
REQ-018 FSM states: IDLE, ISSUE, RDWAIT.
- IDLE: when any request is high, go to ISSUE on the next edge.
- ISSUE: lasts exactly one cycle.
- RDWAIT: lasts RD_LAT cycles.
REQ-019 Arbitration:
- Performed in IDLE.
- A single requester wins.
- If both request, the winner is the requester not granted last (round-robin).
- A last_owner register (reset value CPU) records each grant, so DMA wins the first tie after reset.
REQ-020 In ISSUE:
- ram_addr and ram_data are driven from the winner's addr and wdata, latched at arbitration.
- ram_wren = winner's we.
- The winner's gnt = 1.
REQ-021 Write access: ISSUE goes directly to IDLE; total occupancy is 2 cycles per write.
REQ-022 Read access:
- ISSUE goes to RDWAIT.
- On the final RDWAIT cycle, ram_q is registered into the owner's rdata.
- The owner's rvalid pulses on the following cycle, then the FSM returns to IDLE.
REQ-023 Outside ISSUE: ram_wren = 0; ram_addr and ram_data hold their last values.
REQ-024 rdata SHALL hold its value until that requester's next rvalid.
REQ-025 Requests arriving while the FSM is not in IDLE are held by the requester and arbitrated only on return to IDLE. No request is dropped and no grant is duplicated.
REQ-026 Only one access is outstanding at a time; there is no pipelining.
REQ-027 gnt and rvalid are never asserted to both requesters in the same cycle.
REQ-028 Continuous dual requests alternate CPU, DMA, CPU, ... with no starvation.
REQ-029 A requester deasserting req before gnt is a protocol violation; behaviour is undefined and need not be checked.

Reset
REQ-030 Reset applies on the clk edge where reset = 1, in any state, and aborts any in-flight access.
REQ-031 Reset values:
- State = IDLE; last_owner = CPU.
- All gnt, rvalid and ram_wren = 0.
- rdata, ram_addr and ram_data = 0.
REQ-032 A read aborted by reset SHALL never produce rvalid.

Structure
REQ-033 Shared package mem_arb_pkg holds:
- FSM state encoding (IDLE/ISSUE/RDWAIT);
- requester ID constants (REQ_CPU = 0, REQ_DMA = 1);
- the RD_LAT default.
REQ-034 One sub-module, rr_arb2, is a 2-input round-robin picker (combinational pick plus last_owner register). All remaining logic stays in mem_arbiter.

Verification
REQ-035 Lone CPU write: addr 0x10, wdata 0xDEADBEEF -> cpu_gnt and ram_wren high for exactly one cycle with ram_addr = 0x10; FSM back in IDLE 2 cycles after req.
REQ-036 DMA read, RAM model preloaded with 0x12345678 at address 0x20, RD_LAT = 1 -> dma_gnt at cycle t; dma_rvalid at t+2 with dma_rdata = 0x12345678; cpu_rvalid stays 0.
REQ-037 cpu_req and dma_req raised together right after reset, both writes -> grant order DMA, CPU, DMA, CPU over 8 cycles; gnt pulses never overlap.
REQ-038 CPU read in progress, DMA request arrives during RDWAIT -> dma_gnt only after cpu_rvalid, in the IDLE->ISSUE transition that follows.
REQ-039 reset asserted in RDWAIT of a CPU read -> next cycle all outputs are at reset values; no cpu_rvalid ever appears for that read.
REQ-040 Run with RD_LAT = 3 -> rvalid appears 4 cycles after gnt, and returned data matches the RAM model.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM encoding,
// requester IDs and the default RAM read latency.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RDWAIT = 2'd2
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  localparam int unsigned RD_LAT_DEFAULT = 1;
  localparam int unsigned RD_LAT_MAX     = 3;
  localparam int unsigned LAT_CNT_W      = 2;

  // Round-robin choice between two requesters given the previous owner.
  function automatic logic rr_pick(input logic req_cpu, input logic req_dma,
                                   input logic last_owner);
    logic pick;
    pick = REQ_CPU;
    if (req_cpu && req_dma) begin
      pick = ~last_owner;
    end else if (req_dma) begin
      pick = REQ_DMA;
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: combinational pick plus the last_owner
// register, which only advances when the caller commits a grant.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_cpu,
  input  logic req_dma,
  input  logic take,
  output logic pick_c,
  output logic valid_c
);

  logic last_owner_q;
  logic last_owner_d;

  always_comb begin
    valid_c = req_cpu | req_dma;
    pick_c  = rr_pick(req_cpu, req_dma, last_owner_q);
  end

  always_comb begin
    last_owner_d = last_owner_q;
    if (take && valid_c) begin
      last_owner_d = pick_c;
    end
  end

  // Reset to CPU so the first tie after reset goes to DMA.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner_q <= REQ_CPU;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for a CPU and a DMA requester. One access in
// flight at a time: IDLE arbitrates, ISSUE drives the RAM, RDWAIT collects data.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_LAT = RD_LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,

  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  // RDWAIT counts down from RD_LAT-1; zero marks the cycle ram_q is valid.
  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(RD_LAT - 1);

  state_t              state_q,      state_d;
  logic [LAT_CNT_W-1:0] cnt_q,       cnt_d;
  logic                owner_q,      owner_d;
  logic                we_q,         we_d;
  logic [ADDR_W-1:0]   ram_addr_q,   ram_addr_d;
  logic [DATA_W-1:0]   ram_data_q,   ram_data_d;
  logic                ram_wren_q,   ram_wren_d;
  logic                cpu_gnt_q,    cpu_gnt_d;
  logic                dma_gnt_q,    dma_gnt_d;
  logic                cpu_rvalid_q, cpu_rvalid_d;
  logic                dma_rvalid_q, dma_rvalid_d;
  logic [DATA_W-1:0]   cpu_rdata_q,  cpu_rdata_d;
  logic [DATA_W-1:0]   dma_rdata_q,  dma_rdata_d;

  logic arb_pick_c;
  logic arb_valid_c;
  logic arb_take_c;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset   (reset),
    .req_cpu (cpu_req),
    .req_dma (dma_req),
    .take    (arb_take_c),
    .pick_c  (arb_pick_c),
    .valid_c (arb_valid_c)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    we_d         = we_q;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    ram_wren_d   = 1'b0;
    cpu_gnt_d    = 1'b0;
    dma_gnt_d    = 1'b0;
    cpu_rvalid_d = 1'b0;
    dma_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    arb_take_c   = 1'b0;

    unique case (state_q)
      // Latch the winner's request into the RAM-side registers so it is
      // presented during the ISSUE cycle.
      ST_IDLE: begin
        if (arb_valid_c) begin
          arb_take_c = 1'b1;
          owner_d    = arb_pick_c;
          state_d    = ST_ISSUE;
          if (arb_pick_c == REQ_DMA) begin
            we_d       = dma_we;
            ram_addr_d = dma_addr;
            ram_data_d = dma_wdata;
            ram_wren_d = dma_we;
            dma_gnt_d  = 1'b1;
          end else begin
            we_d       = cpu_we;
            ram_addr_d = cpu_addr;
            ram_data_d = cpu_wdata;
            ram_wren_d = cpu_we;
            cpu_gnt_d  = 1'b1;
          end
        end
      end

      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RDWAIT;
          cnt_d   = LAT_LAST;
        end
      end

      ST_RDWAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          if (owner_q == REQ_DMA) begin
            dma_rdata_d  = ram_q;
            dma_rvalid_d = 1'b1;
          end else begin
            cpu_rdata_d  = ram_q;
            cpu_rvalid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset aborts any in-flight access, so a reset read never returns rvalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      owner_q      <= REQ_CPU;
      we_q         <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      ram_wren_q   <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      dma_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      ram_wren_q   <= ram_wren_d;
      cpu_gnt_q    <= cpu_gnt_d;
      dma_gnt_q    <= dma_gnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dma_rvalid_q <= dma_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  assign cpu_gnt    = cpu_gnt_q;
  assign dma_gnt    = dma_gnt_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dma_rvalid = dma_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rdata  = dma_rdata_q;
  assign ram_addr   = ram_addr_q;
  assign ram_data   = ram_data_q;
  assign ram_wren   = ram_wren_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at RD_LAT=1 with a 1-cycle
// RAM model, a second at RD_LAT=3 with a 3-stage RAM model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [7:0]  cpu_addr, dma_addr;
  logic [31:0] cpu_wdata, dma_wdata;
  logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [31:0] cpu_rdata, dma_rdata;
  logic [7:0]  ram_addr;
  logic [31:0] ram_data, ram_q;
  logic        ram_wren;

  logic        c3_req, c3_we, d3_req, d3_we;
  logic [7:0]  c3_addr, d3_addr;
  logic [31:0] c3_wdata, d3_wdata;
  logic        c3_gnt, c3_rvalid, d3_gnt, d3_rvalid;
  logic [31:0] c3_rdata, d3_rdata;
  logic [7:0]  ram3_addr;
  logic [31:0] ram3_data, ram3_q;
  logic        ram3_wren;

  logic        tb_we;
  logic [7:0]  tb_waddr;
  logic [31:0] tb_wdata;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.DATA_W(32), .ADDR_W(8), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  mem_arbiter #(.DATA_W(32), .ADDR_W(8), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset),
    .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
    .cpu_gnt(c3_gnt), .cpu_rvalid(c3_rvalid), .cpu_rdata(c3_rdata),
    .dma_req(d3_req), .dma_we(d3_we), .dma_addr(d3_addr), .dma_wdata(d3_wdata),
    .dma_gnt(d3_gnt), .dma_rvalid(d3_rvalid), .dma_rdata(d3_rdata),
    .ram_addr(ram3_addr), .ram_data(ram3_data), .ram_wren(ram3_wren), .ram_q(ram3_q)
  );

  // RAM models: data appears RD_LAT cycles after the address is presented.
  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];
  logic [31:0] s1, s2;

  always @(posedge clk) begin
    if (tb_we) mem1[tb_waddr] <= tb_wdata;
    else if (ram_wren) mem1[ram_addr] <= ram_data;
    ram_q <= mem1[ram_addr];
  end

  always @(posedge clk) begin
    if (tb_we) mem3[tb_waddr] <= tb_wdata;
    else if (ram3_wren) mem3[ram3_addr] <= ram3_data;
    s1     <= mem3[ram3_addr];
    s2     <= s1;
    ram3_q <= s2;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    {cpu_req, cpu_we, dma_req, dma_we} = '0;
    {c3_req, c3_we, d3_req, d3_we} = '0;
    cpu_addr = '0; dma_addr = '0; c3_addr = '0; d3_addr = '0;
    cpu_wdata = '0; dma_wdata = '0; c3_wdata = '0; d3_wdata = '0;
    tb_we = 1'b1;
    tb_waddr = 8'h20; tb_wdata = 32'h1234_5678; tick();
    tb_waddr = 8'h50; tb_wdata = 32'hCAFE_F00D; tick();
    tb_waddr = 8'h44; tb_wdata = 32'hA5A5_0F0F; tick();
    tb_we = 1'b0;
    n_cmp++;
    if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, ram_wren} !== 5'b0) begin
      n_err++;
      $display("FAIL rst_ctrl: got %b want 00000",
               {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, ram_wren});
    end
    n_cmp++;
    if ({cpu_rdata, dma_rdata, ram_data} !== 96'h0 || ram_addr !== 8'h0) begin
      n_err++;
      $display("FAIL rst_data: got %h %h %h %h want all 0", cpu_rdata, dma_rdata,
               ram_data, ram_addr);
    end
    n_cmp++;
    if (dut.state_q !== ST_IDLE) begin
      n_err++;
      $display("FAIL rst_state: got %0d want %0d", dut.state_q, ST_IDLE);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_cpu_write();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 32'hDEAD_BEEF;
    tick();
    n_cmp++;
    if ({cpu_gnt, ram_wren, dma_gnt} !== 3'b110 || ram_addr !== 8'h10 ||
        ram_data !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL wr_issue: got gnt/wren/dgnt=%b addr=%h data=%h want 110 10 deadbeef",
               {cpu_gnt, ram_wren, dma_gnt}, ram_addr, ram_data);
    end
    cpu_req = 1'b0;
    tick();
    n_cmp++;
    if ({cpu_gnt, ram_wren} !== 2'b00 || ram_addr !== 8'h10 || dut.state_q !== ST_IDLE) begin
      n_err++;
      $display("FAIL wr_after: got gnt/wren=%b addr=%h state=%0d want 00 10 IDLE",
               {cpu_gnt, ram_wren}, ram_addr, dut.state_q);
    end
    n_cmp++;
    if (mem1[8'h10] !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL wr_mem: got %h want deadbeef", mem1[8'h10]);
    end
  endtask

  task automatic test_dma_read();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h20;
    tick();
    n_cmp++;
    if ({dma_gnt, cpu_gnt, ram_wren} !== 3'b100 || ram_addr !== 8'h20) begin
      n_err++;
      $display("FAIL rd_gnt: got gnt/cgnt/wren=%b addr=%h want 100 20",
               {dma_gnt, cpu_gnt, ram_wren}, ram_addr);
    end
    dma_req = 1'b0;
    tick();
    n_cmp++;
    if (dma_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL rd_early: got rvalid=%b want 0", dma_rvalid);
    end
    tick();
    n_cmp++;
    if (dma_rvalid !== 1'b1 || dma_rdata !== 32'h1234_5678 || cpu_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL rd_data: got rv=%b data=%h crv=%b want 1 12345678 0",
               dma_rvalid, dma_rdata, cpu_rvalid);
    end
    tick();
    n_cmp++;
    if (dma_rvalid !== 1'b0 || dma_rdata !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL rd_hold: got rv=%b data=%h want 0 12345678", dma_rvalid, dma_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_dma;
    logic [7:0] exp_cpu;
    exp_dma = 8'b0001_0001;
    exp_cpu = 8'b0100_0100;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 32'h0000_0C0C;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h40; dma_wdata = 32'h0000_0D0D;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (cpu_gnt !== exp_cpu[i] || dma_gnt !== exp_dma[i]) begin
        n_err++;
        $display("FAIL rr_cycle%0d: got cpu=%b dma=%b want cpu=%b dma=%b",
                 i, cpu_gnt, dma_gnt, exp_cpu[i], exp_dma[i]);
      end
      if (i == 6) begin
        cpu_req = 1'b0;
        dma_req = 1'b0;
      end
    end
    n_cmp++;
    if (mem1[8'h30] !== 32'h0000_0C0C || mem1[8'h40] !== 32'h0000_0D0D) begin
      n_err++;
      $display("FAIL rr_mem: got %h %h want 00000c0c 00000d0d", mem1[8'h30], mem1[8'h40]);
    end
  endtask

  task automatic test_cpu_read_dma_wait();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h50;
    tick();
    n_cmp++;
    if (cpu_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL cr_gnt: got %b want 1", cpu_gnt);
    end
    cpu_req = 1'b0;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h60; dma_wdata = 32'h0000_0055;
    tick();
    n_cmp++;
    if (dma_gnt !== 1'b0 || cpu_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL cr_wait: got dgnt=%b crv=%b want 0 0", dma_gnt, cpu_rvalid);
    end
    tick();
    n_cmp++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hCAFE_F00D || dma_gnt !== 1'b0) begin
      n_err++;
      $display("FAIL cr_data: got rv=%b data=%h dgnt=%b want 1 cafef00d 0",
               cpu_rvalid, cpu_rdata, dma_gnt);
    end
    tick();
    n_cmp++;
    if (dma_gnt !== 1'b1 || cpu_rvalid !== 1'b0 || ram_addr !== 8'h60) begin
      n_err++;
      $display("FAIL cr_dgnt: got dgnt=%b crv=%b addr=%h want 1 0 60",
               dma_gnt, cpu_rvalid, ram_addr);
    end
    dma_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_rdwait();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
    tick();
    cpu_req = 1'b0;
    tick();
    n_cmp++;
    if (dut.state_q !== ST_RDWAIT) begin
      n_err++;
      $display("FAIL ra_state: got %0d want %0d", dut.state_q, ST_RDWAIT);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, ram_wren} !== 5'b0 ||
        {cpu_rdata, dma_rdata, ram_data} !== 96'h0 || ram_addr !== 8'h0) begin
      n_err++;
      $display("FAIL ra_outs: got ctl=%b rd=%h/%h ram=%h/%h want all 0",
               {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, ram_wren},
               cpu_rdata, dma_rdata, ram_addr, ram_data);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin
        n_err++;
        $display("FAIL ra_norv%0d: got rv=%b data=%h want 0 0", i, cpu_rvalid, cpu_rdata);
      end
    end
  endtask

  task automatic test_rdlat3();
    c3_req = 1'b1; c3_we = 1'b0; c3_addr = 8'h44;
    tick();
    n_cmp++;
    if (c3_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL l3_gnt: got %b want 1", c3_gnt);
    end
    c3_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_cmp++;
      if (c3_rvalid !== 1'b0) begin
        n_err++;
        $display("FAIL l3_early%0d: got rv=%b want 0", k, c3_rvalid);
      end
    end
    tick();
    n_cmp++;
    if (c3_rvalid !== 1'b1 || c3_rdata !== 32'hA5A5_0F0F) begin
      n_err++;
      $display("FAIL l3_data: got rv=%b data=%h want 1 a5a50f0f", c3_rvalid, c3_rdata);
    end
    tick();
    n_cmp++;
    if (c3_rvalid !== 1'b0 || d3_gnt !== 1'b0 || d3_rvalid !== 1'b0 || d3_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL l3_after: got rv=%b dgnt=%b drv=%b drd=%h want 0 0 0 0",
               c3_rvalid, d3_gnt, d3_rvalid, d3_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_dma_read();
    test_back_to_back();
    test_cpu_read_dma_wait();
    test_reset_in_rdwait();
    test_rdlat3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
